// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider producing one quotient bit per clock.
// Start/done handshake; results are held until the next operation completes.
// Optional two's-complement support is compiled in when DIV_SIGNED_EN is defined.
module div_iter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);
    localparam logic [CW-1:0] AllIter  = CW'(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;     // partial remainder R
    logic [WIDTH-1:0] quo_q;     // dividend shifts out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvsr_q;
    logic             zero_q;

    logic [WIDTH-1:0] dvnd_mag;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] dvnd_raw_q;  // original dividend, returned on divide by zero
    logic             dvnd_neg;
    logic             dvsr_neg;
    logic             unused_bits;

    // Operand magnitudes for the unsigned core
    assign dvnd_neg = is_signed & dividend_in[WIDTH-1];
    assign dvsr_neg = is_signed & divisor_in[WIDTH-1];
    assign dvnd_mag = dvnd_neg ? -dividend_in : dividend_in;
    assign dvsr_mag = dvsr_neg ? -divisor_in : divisor_in;

    // Sign fixup applied on the edge that raises done; most-negative / -1 falls out naturally
    assign quo_fix = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign rem_fix = zero_q ? dvnd_raw_q
                            : (neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]);

    // R never exceeds the divisor, so its top bit is always clear at completion
    assign unused_bits = rem_q[WIDTH];
`else
    logic unused_bits;

    assign dvnd_mag = dividend_in;
    assign dvsr_mag = divisor_in;

    // With a zero divisor every trial succeeds and R collects the dividend unchanged
    assign quo_fix = zero_q ? '1 : quo_q;
    assign rem_fix = rem_q[WIDTH-1:0];

    assign unused_bits = ^{rem_q[WIDTH], is_signed};
`endif

    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_ge;

    // One restoring step: shift in the next dividend bit and try subtracting the divisor
    assign r_shift  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial    = {1'b0, r_shift} - {2'b00, dvsr_q};
    assign trial_ge = ~trial[WIDTH+1];

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            zero_q        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dvnd_raw_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StBusy;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= dvnd_mag;
                        dvsr_q  <= dvsr_mag;
                        zero_q  <= (divisor_in == '0);
`ifdef DIV_SIGNED_EN
                        neg_quo_q  <= dvnd_neg ^ dvsr_neg;
                        neg_rem_q  <= dvnd_neg;
                        dvnd_raw_q <= dividend_in;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    if (cnt_q != AllIter) begin
                        rem_q <= trial_ge ? trial[WIDTH:0] : r_shift;
                        quo_q <= {quo_q[WIDTH-2:0], trial_ge};
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LastIter) begin
                            busy <= 1'b0;
                        end
                    end else begin
                        state_q       <= StDone;
                        done          <= 1'b1;
                        div_by_zero   <= zero_q;
                        quotient_out  <= quo_fix;
                        remainder_out <= rem_fix;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors for div_iter with a queue-based scoreboard.
// Stimulus pushes expected results; an independent monitor pops on each done pulse.
module tb_div_iter;

    localparam int unsigned W = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend_in;
    logic [W-1:0] divisor_in;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient_out;
    logic [W-1:0] remainder_out;

    div_iter #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .is_signed     (is_signed),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (div_by_zero),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    int          busy_run = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_done: done with no pending operation at cycle %0d",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient_out, e.q);
                    check("remainder", remainder_out, e.r);
                    check("div_by_zero", W'(div_by_zero), W'(e.dz));
                    check("done_cycle", W'(cyc), W'(e.cyc));
                    check("busy_cycles", W'(busy_run), W'(W));
                end
                busy_run = 0;
            end
        end
    end

    // Issue one operation; with in_done set, the start is raised in the done cycle
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input bit in_done);
        exp_t e;
        bit   seen;
        if (in_done) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clock);
                if (done) seen = 1'b1;
            end
            if (!seen) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_done: done never seen before back-to-back start");
            end
        end else begin
            @(negedge clock);
        end
        start       = 1'b1;
        dividend_in = a;
        divisor_in  = b;
        is_signed   = s;
        @(negedge clock);
        start = 1'b0;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.cyc = cyc + W + 1;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, W'(busy), '0);
        check({tag, "_done"}, W'(done), '0);
        check({tag, "_dz"}, W'(div_by_zero), '0);
        check({tag, "_quotient"}, quotient_out, '0);
        check({tag, "_remainder"}, remainder_out, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        is_signed   = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic division, latency and busy length
        issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 1'b0);
        drain(200);

        // Start 10 cycles into BUSY is ignored
        issue(64'd1003, 64'd10, 1'b0, 64'd100, 64'd3, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        start       = 1'b1;
        dividend_in = 64'd77;
        divisor_in  = 64'd3;
        @(negedge clock);
        start = 1'b0;
        drain(200);

        // Back-to-back: second start raised in the DONE cycle
        issue(64'd1000, 64'd3, 1'b0, 64'd333, 64'd1, 1'b0, 1'b0);
        issue(64'd12345, 64'd100, 1'b0, 64'd123, 64'd45, 1'b0, 1'b1);
        drain(200);

        // Divide by zero
        issue(64'hDEAD_BEEF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF, 1'b1, 1'b0);
        drain(200);

        // Reset at iteration 30 aborts without a done
        issue(64'd999_999, 64'd13, 1'b0, 64'd76923, 64'd0, 1'b0, 1'b0);
        repeat (29) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sb.delete();
        check_reset_outputs("abort");
        reset = 1'b0;
        repeat (80) @(negedge clock);

        // Reset and start together: reset wins
        reset       = 1'b1;
        start       = 1'b1;
        dividend_in = 64'd50;
        divisor_in  = 64'd5;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("rst_start_busy", W'(busy), '0);
        repeat (80) @(negedge clock);

        // Extremes
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0);
        issue(64'd5, 64'd9, 1'b0, 64'd0, 64'd5, 1'b0, 1'b1);
        drain(300);

        // Signed operands interpreted as unsigned
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 64'd2635249153387078788, 64'd0, 1'b0, 1'b0);
        issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'd0, 64'd100, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        drain(300);

`ifdef DIV_SIGNED_EN
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C, 1'b1, 1'b1);
        drain(400);
`else
        // is_signed has no effect in the unsigned build
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 64'd2635249153387078788, 64'd0, 1'b0, 1'b0);
        issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'd0, 64'd100, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        drain(300);
`endif

        repeat (5) @(negedge clock);
        check("scoreboard_empty", W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
